// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: one registered mux level per shift-amount bit.
// Supports LSL/LSR/ASR/ROL/ROR/PASS with carry-out and zero flag.
module barrel_shift_pipe #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    localparam logic [2:0] M_LSL = 3'd0;
    localparam logic [2:0] M_LSR = 3'd1;
    localparam logic [2:0] M_ASR = 3'd2;
    localparam logic [2:0] M_ROL = 3'd3;
    localparam logic [2:0] M_ROR = 3'd4;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // One mux level: shift/rotate by s when en, returns {carry, data}.
    function automatic logic [WIDTH:0] lvl(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       m,
        input logic             sg,
        input logic             c,
        input logic             en,
        input int               s
    );
        logic [WIDTH-1:0] r;
        logic             co;
        r  = d;
        co = c;
        if (en) begin
            case (m)
                M_LSL: begin
                    r  = d << s;
                    co = |(d & (ONE << (WIDTH - s)));
                end
                M_LSR: begin
                    r  = d >> s;
                    co = |(d & (ONE << (s - 1)));
                end
                M_ASR: begin
                    r  = (d >> s) | ({WIDTH{sg}} & ~({WIDTH{1'b1}} >> s));
                    co = |(d & (ONE << (s - 1)));
                end
                M_ROL: begin
                    r  = (d << s) | (d >> (WIDTH - s));
                    co = r[0];
                end
                M_ROR: begin
                    r  = (d >> s) | (d << (WIDTH - s));
                    co = r[WIDTH-1];
                end
                default: begin
                    r  = d;
                    co = c;
                end
            endcase
        end
        return {co, r};
    endfunction

    logic [WIDTH-1:0] sd [SHW];
    logic [SHW-1:0]   sa [SHW];
    logic [2:0]       sm [SHW];
    logic             ss [SHW];
    logic             sc [SHW];
    logic             sv [SHW];
    logic [WIDTH:0]   nx [SHW];

    logic [WIDTH-1:0] rd [SHW];
    logic [SHW-1:0]   ra [SHW];
    logic [2:0]       rm [SHW];
    logic             rs [SHW];
    logic             rc [SHW];
    logic             rv [SHW];
    logic             rz;
    logic             stall;

    assign stall     = rv[SHW-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = rv[SHW-1];
    assign out_data  = rd[SHW-1];
    assign out_carry = rc[SHW-1];
    assign out_zero  = rz;

    for (genvar k = 0; k < SHW; k++) begin : g_lvl
        if (k == 0) begin : g_head
            assign sd[k] = in_data;
            assign sa[k] = in_amt;
            assign sm[k] = in_mode;
            assign ss[k] = in_data[WIDTH-1];
            assign sc[k] = 1'b0;
            assign sv[k] = in_valid;
        end else begin : g_link
            assign sd[k] = rd[k-1];
            assign sa[k] = ra[k-1];
            assign sm[k] = rm[k-1];
            assign ss[k] = rs[k-1];
            assign sc[k] = rc[k-1];
            assign sv[k] = rv[k-1];
        end

        assign nx[k] = lvl(sd[k], sm[k], ss[k], sc[k], sa[k][k], 1 << k);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd[k] <= '0;
                ra[k] <= '0;
                rm[k] <= '0;
                rs[k] <= 1'b0;
                rc[k] <= 1'b0;
                rv[k] <= 1'b0;
            end else if (!stall) begin
                rd[k] <= nx[k][WIDTH-1:0];
                ra[k] <= sa[k];
                rm[k] <= sm[k];
                rs[k] <= ss[k];
                rc[k] <= nx[k][WIDTH];
                rv[k] <= sv[k];
            end
        end
    end

    // Zero flag is registered alongside the final data so it resets to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rz <= 1'b0;
        end else if (!stall) begin
            rz <= ~|nx[SHW-1][WIDTH-1:0];
        end
    end

endmodule
